cofi_timing_ctrl: RTL and testbench

//   Video timing sequencer for the composite-blend (cofi) stage.
//   - Generates pixel clock-enable, h/v counters, blanking and sync pulses that

---
 rtl/cofi_timing_ctrl_if.sv | 32 +++
 rtl/cofi_timing_ctrl.sv | 150 +++++++++++++++
 tb/tb_cofi_timing_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cofi_timing_ctrl_if.sv
// Timing bus between cofi_timing_ctrl (master) and the composite blender (slave).
// The frame_start strobe exists only when COFI_FRAME_STROBE_EN is defined.
interface cofi_timing_ctrl_if;
   logic       blend_req;
   logic       pix_ce;
   logic       blend_en;
   logic [8:0] hcount;
   logic [8:0] vcount;
   logic       hblank;
   logic       vblank;
   logic       hs;
   logic       vs;
`ifdef COFI_FRAME_STROBE_EN
   logic       frame_start;
`endif

   modport master (
      input  blend_req,
      output pix_ce, blend_en, hcount, vcount, hblank, vblank, hs, vs
`ifdef COFI_FRAME_STROBE_EN
      , output frame_start
`endif
   );

   modport slave (
      output blend_req,
      input  pix_ce, blend_en, hcount, vcount, hblank, vblank, hs, vs
`ifdef COFI_FRAME_STROBE_EN
      , input frame_start
`endif
   );
endinterface

// File: rtl/cofi_timing_ctrl.sv
// cofi_timing_ctrl: video timing sequencer for the composite-blend stage.
// Produces pixel strobe, h/v counters, blanking and sync, and a blend enable
// that only changes on the frame-wrap edge so the blender never switches mode
// mid-frame. Optional COFI_FRAME_STROBE_EN adds a one-clk frame_start strobe.
module cofi_timing_ctrl #(
   parameter int CE_DIV   = 4,
   parameter int H_ACTIVE = 256,
   parameter int H_FP     = 8,
   parameter int H_SYNC   = 24,
   parameter int H_BP     = 32,
   parameter int V_ACTIVE = 224,
   parameter int V_FP     = 8,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 27
) (
   input  logic               clk,
   input  logic               reset,
   cofi_timing_ctrl_if.master tmg
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counters are a fixed 9 bits wide; larger rasters cannot be represented.
   if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_size_chk
      $error("cofi_timing_ctrl: H_TOTAL=%0d / V_TOTAL=%0d exceed 9-bit counters", H_TOTAL, V_TOTAL);
   end
   if (CE_DIV < 1 || CE_DIV > 16) begin : g_div_chk
      $error("cofi_timing_ctrl: CE_DIV=%0d outside 1..16", CE_DIV);
   end

   localparam logic [4:0] DIV_LAST = 5'(CE_DIV - 1);
   localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
   // Decode bounds kept 10 bits wide so a sync ending exactly at 512 does not wrap.
   localparam logic [9:0] H_ACT10  = 10'(H_ACTIVE);
   localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_ACT10  = 10'(V_ACTIVE);
   localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [4:0] div_q, div_d;
   logic       pix_ce_q, pix_ce_d;
   logic [8:0] hcount_q, hcount_d;
   logic [8:0] vcount_q, vcount_d;
   logic       hblank_q, hblank_d;
   logic       vblank_q, vblank_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blend_en_q, blend_en_d;
   logic       frame_wrap_s;
   logic [9:0] hnext_s, vnext_s;

   // Next-state: divider, raster counters, decodes of the next counter values, blend sampling.
   always_comb begin
      div_d        = div_q;
      pix_ce_d     = 1'b0;
      hcount_d     = hcount_q;
      vcount_d     = vcount_q;
      frame_wrap_s = 1'b0;
      blend_en_d   = blend_en_q;

      if (div_q == DIV_LAST) begin
         div_d    = 5'd0;
         pix_ce_d = 1'b1;
      end else begin
         div_d    = div_q + 5'd1;
         pix_ce_d = 1'b0;
      end

      if (pix_ce_d) begin
         if (hcount_q == H_LAST) begin
            hcount_d = 9'd0;
            if (vcount_q == V_LAST) begin
               vcount_d     = 9'd0;
               frame_wrap_s = 1'b1;
            end else begin
               vcount_d = vcount_q + 9'd1;
            end
         end else begin
            hcount_d = hcount_q + 9'd1;
         end
      end else begin
         hcount_d = hcount_q;
      end

      if (frame_wrap_s) begin
         blend_en_d = tmg.blend_req;
      end else begin
         blend_en_d = blend_en_q;
      end

      // Counters hold between strobes, so these decodes hold too.
      hnext_s  = {1'b0, hcount_d};
      vnext_s  = {1'b0, vcount_d};
      hblank_d = (hnext_s >= H_ACT10);
      vblank_d = (vnext_s >= V_ACT10);
      hs_d     = (hnext_s >= HS_BEG) && (hnext_s < HS_END);
      vs_d     = (vnext_s >= VS_BEG) && (vnext_s < VS_END);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= 5'd0;
         pix_ce_q   <= 1'b0;
         hcount_q   <= 9'd0;
         vcount_q   <= 9'd0;
         hblank_q   <= 1'b0;
         vblank_q   <= 1'b0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         blend_en_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         pix_ce_q   <= pix_ce_d;
         hcount_q   <= hcount_d;
         vcount_q   <= vcount_d;
         hblank_q   <= hblank_d;
         vblank_q   <= vblank_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         blend_en_q <= blend_en_d;
      end
   end

`ifdef COFI_FRAME_STROBE_EN
   logic frame_start_q;

   // One-clk strobe on the frame-wrap edge, aligned with (0,0) and the blend_en update.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_start_q <= 1'b0;
      end else begin
         frame_start_q <= frame_wrap_s;
      end
   end

   assign tmg.frame_start = frame_start_q;
`endif

   assign tmg.pix_ce   = pix_ce_q;
   assign tmg.blend_en = blend_en_q;
   assign tmg.hcount   = hcount_q;
   assign tmg.vcount   = vcount_q;
   assign tmg.hblank   = hblank_q;
   assign tmg.vblank   = vblank_q;
   assign tmg.hs       = hs_q;
   assign tmg.vs       = vs_q;
endmodule

// File: tb/tb_cofi_timing_ctrl.sv
// Bench for cofi_timing_ctrl: three instances (default raster, small raster,
// CE_DIV=1 tiny line) checked every clk against an arithmetic raster model.
module tb_cofi_timing_ctrl;
   logic clk = 1'b0;
   logic reset;
   logic breq;
   int   n;
   int   n_assert = 0;
   int   n_fail   = 0;
   logic eb_d, eb_s, eb_t;
   logic fs_d, fs_s, fs_t;

   always #5 clk = ~clk;

   cofi_timing_ctrl_if if_d ();
   cofi_timing_ctrl_if if_s ();
   cofi_timing_ctrl_if if_t ();

   assign if_d.blend_req = breq;
   assign if_s.blend_req = breq;
   assign if_t.blend_req = breq;

   cofi_timing_ctrl u_def (.clk(clk), .reset(reset), .tmg(if_d));

   cofi_timing_ctrl #(.CE_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                      .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3))
      u_small (.clk(clk), .reset(reset), .tmg(if_s));

   cofi_timing_ctrl #(.CE_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1))
      u_tiny (.clk(clk), .reset(reset), .tmg(if_t));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
      end
   endtask

   // Frame wrap happens on a strobe edge whose pixel index is a whole number of frames.
   function automatic bit fwrap(input int nn, input int ce, input int fr);
      return (nn > 0) && (nn % ce == 0) && ((nn / ce) % fr == 0);
   endfunction

   task automatic check_inst(input string nm, input int ce, input int ht, input int ha,
                             input int hsb, input int hse, input int vt, input int va,
                             input int vsb, input int vse,
                             input logic pce, input logic [8:0] hc, input logic [8:0] vc,
                             input logic hbl, input logic vbl, input logic hsy, input logic vsy,
                             input logic ben, input logic eben);
      int p, ehc, evc;
      p   = n / ce;
      ehc = p % ht;
      evc = (p / ht) % vt;
      chk({nm, ".pix_ce"},   32'(pce), 32'((n > 0) && (n % ce == 0)));
      chk({nm, ".hcount"},   32'(hc),  32'(ehc));
      chk({nm, ".vcount"},   32'(vc),  32'(evc));
      chk({nm, ".hblank"},   32'(hbl), 32'(ehc >= ha));
      chk({nm, ".vblank"},   32'(vbl), 32'(evc >= va));
      chk({nm, ".hs"},       32'(hsy), 32'((ehc >= hsb) && (ehc < hse)));
      chk({nm, ".vs"},       32'(vsy), 32'((evc >= vsb) && (evc < vse)));
      chk({nm, ".blend_en"}, 32'(ben), 32'(eben));
   endtask

   // One clk: update the model at the edge, then compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (reset) begin
         n = 0;
         eb_d = 1'b0; eb_s = 1'b0; eb_t = 1'b0;
         fs_d = 1'b0; fs_s = 1'b0; fs_t = 1'b0;
      end else begin
         n++;
         fs_d = fwrap(n, 4, 320 * 262);
         fs_s = fwrap(n, 3, 25 * 17);
         fs_t = fwrap(n, 1, 7 * 262);
         if (fs_d) eb_d = breq;
         if (fs_s) eb_s = breq;
         if (fs_t) eb_t = breq;
      end
      @(negedge clk);
      check_inst("def", 4, 320, 256, 264, 288, 262, 224, 232, 235,
                 if_d.pix_ce, if_d.hcount, if_d.vcount, if_d.hblank, if_d.vblank,
                 if_d.hs, if_d.vs, if_d.blend_en, eb_d);
      check_inst("small", 3, 25, 16, 18, 21, 17, 10, 12, 14,
                 if_s.pix_ce, if_s.hcount, if_s.vcount, if_s.hblank, if_s.vblank,
                 if_s.hs, if_s.vs, if_s.blend_en, eb_s);
      check_inst("tiny", 1, 7, 4, 5, 6, 262, 224, 232, 235,
                 if_t.pix_ce, if_t.hcount, if_t.vcount, if_t.hblank, if_t.vblank,
                 if_t.hs, if_t.vs, if_t.blend_en, eb_t);
`ifdef COFI_FRAME_STROBE_EN
      chk("def.frame_start",   32'(if_d.frame_start), 32'(fs_d));
      chk("small.frame_start", 32'(if_s.frame_start), 32'(fs_s));
      chk("tiny.frame_start",  32'(if_t.frame_start), 32'(fs_t));
`endif
   endtask

   initial begin
      n = 0;
      eb_d = 1'b0; eb_s = 1'b0; eb_t = 1'b0;
      fs_d = 1'b0; fs_s = 1'b0; fs_t = 1'b0;
      reset = 1'b1;
      breq  = 1'b1;
      @(negedge clk);
      repeat (3) cycle();
      reset = 1'b0;

      // Random blend requests across the first small-raster frame wrap (n=1275).
      repeat (1300) begin
         breq = 1'($urandom_range(0, 1));
         cycle();
      end
      // 1300 clks = 325 pixels on the default raster: one line wrapped.
      chk("def.line_wrap.vcount", 32'(if_d.vcount), 32'd1);
      chk("def.line_wrap.hcount", 32'(if_d.hcount), 32'd5);

      // Hold blend_req high through the wrap at n=2550.
      breq = 1'b1;
      while (n < 2600) cycle();
      chk("small.blend_hold", 32'(if_s.blend_en), 32'd1);

      // Low through the wrap at n=3825, then a pulse that ends before n=5100.
      breq = 1'b0;
      while (n < 3900) cycle();
      chk("small.blend_low", 32'(if_s.blend_en), 32'd0);
      while (n < 5110) begin
         breq = (n >= 4200 && n < 4600) ? 1'b1 : 1'b0;
         cycle();
      end
      chk("small.blend_pulse_ignored", 32'(if_s.blend_en), 32'd0);

      // Hold high through the wrap at n=6375, then reset mid-frame.
      breq = 1'b1;
      while (n < 6975) cycle();
      chk("small.blend_before_reset", 32'(if_s.blend_en), 32'd1);
      reset = 1'b1;
      cycle();
      chk("small.reset.blend_en", 32'(if_s.blend_en), 32'd0);
      chk("small.reset.hcount",   32'(if_s.hcount),   32'd0);
      reset = 1'b0;
      repeat (2) cycle();
      chk("small.first_ce.early", 32'(if_s.pix_ce), 32'd0);
      cycle();
      chk("small.first_ce", 32'(if_s.pix_ce), 32'd1);
      cycle();
      chk("def.first_ce", 32'(if_d.pix_ce), 32'd1);
      repeat (50) begin
         breq = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
